array_key_scan: RTL

- Scans a 4×4 matrix keypad, debounces press and release, and emits one 4-bit key code per physical press as a single-cycle valid pulse.
- Sits directly upstream of the keypad-to-decimal converter: `key_num`/`key_vld` drive its `din`/`din_vld`.
- Columns are active-low outputs. Rows are active-low inputs with external pull-ups.

---
 rtl/array_key_pkg.sv | 22 ++
 rtl/key_sync.sv | 25 ++
 rtl/array_key_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/array_key_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package array_key_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam logic [KEY_COLS-1:0] COL_IDLE = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        REPORT,
        RELEASE
    } state_e;

    // Index of the lowest-numbered active-low row; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [KEY_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = KEY_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction
endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module key_sync #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/array_key_scan.sv
// 4x4 matrix keypad scanner: debounced press/release, one key-code pulse per press.
module array_key_scan
    import array_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SCAN_CYC     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_ROWS-1:0] key_row,
    output logic [KEY_COLS-1:0] key_col,
    output logic [3:0]          key_num,
    output logic                key_vld
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);

    logic [KEY_ROWS-1:0] row_s;
    logic                pressed;

    state_e        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic          hit_q, hit_d;
    logic [1:0]    hit_row_q, hit_row_d;
    logic [1:0]    hit_col_q, hit_col_d;
    logic [3:0]    key_num_q, key_num_d;
    logic          key_vld_q, key_vld_d;

    key_sync #(
        .WIDTH  (KEY_ROWS),
        .RST_VAL('1)
    ) u_row_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (key_row),
        .q_o  (row_s)
    );

    assign pressed = ~&row_s;
    // Saturating so a stuck count can never wrap back through DEB_MAX.
    assign deb_inc = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            scan_cnt_q <= '0;
            col_idx_q  <= '0;
            hit_q      <= 1'b0;
            hit_row_q  <= '0;
            hit_col_q  <= '0;
            key_num_q  <= '0;
            key_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            col_idx_q  <= col_idx_d;
            hit_q      <= hit_d;
            hit_row_q  <= hit_row_d;
            hit_col_q  <= hit_col_d;
            key_num_q  <= key_num_d;
            key_vld_q  <= key_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        scan_cnt_d = scan_cnt_q;
        col_idx_d  = col_idx_q;
        hit_d      = hit_q;
        hit_row_d  = hit_row_q;
        hit_col_d  = hit_col_q;
        key_num_d  = key_num_q;
        key_vld_d  = 1'b0;
        key_col    = COL_IDLE;
        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (pressed) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!pressed) begin
                    deb_cnt_d = '0;
                    state_d   = IDLE;
                end else if (deb_inc == DEB_MAX) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_idx_d  = '0;
                    hit_d      = 1'b0;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            SCAN: begin
                key_col = ~(4'b0001 << col_idx_q);
                // Sample only at the window end so the synchronized rows reflect this column.
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (!hit_q && pressed) begin
                        hit_d     = 1'b1;
                        hit_row_d = lowest_low(row_s);
                        hit_col_d = col_idx_q;
                    end
                    if (col_idx_q == 2'd3) state_d = REPORT;
                    else col_idx_d = col_idx_q + 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            REPORT: begin
                if (hit_q) begin
                    key_num_d = {hit_row_q, hit_col_q};
                    key_vld_d = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
                end else begin
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (pressed) begin
                    deb_cnt_d = '0;
                end else if (deb_inc == DEB_MAX) begin
                    deb_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_num = key_num_q;
    assign key_vld = key_vld_q;
endmodule
